// File: rtl/uart_pkg.sv
// uart_pkg: shared types, default sizes and small helpers for the UART blocks.
// Holds the receiver state enum and the parity helper shared with uart_tx.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Even-parity bit of a word; zero-extend narrower words to 32 bits.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

    function automatic logic majority3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for idle-high async inputs.
// Ports: clk, nrst (sync, active-high, resets both flops to 1), d in, q out.
module uart_sync2 (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 receiver with valid/ack output and sticky error flags.
// Ports: baud_clk, nrst (sync, active-high), sin, rx_ack -> dout, rx_valid,
// busy_rx, frame_err, overrun; parity_err only with UART_RX_PARITY_EN defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 baud_clk,
    input  logic                 nrst,
    input  logic                 sin,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_valid,
    output logic                 busy_rx,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] T_LO   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_HI   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 s_sync;
    logic                 s_prev_q, s_prev_d;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
`endif
    logic                 maj;
    logic                 load;

    uart_sync2 u_sync (
        .clk  (baud_clk),
        .nrst (nrst),
        .d    (sin),
        .q    (s_sync)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        samp_d   = samp_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        ferr_d   = ferr_q;
        ovr_d    = ovr_q;
`ifdef UART_RX_PARITY_EN
        perr_d   = perr_q;
`endif
        s_prev_d = s_sync;
        load     = 1'b0;
        // Third vote is the live sample at MID+1.
        maj      = majority3(samp_q[1], samp_q[0], s_sync);

        if (cnt_q == T_LO) samp_d[1] = s_sync;
        if (cnt_q == T_MID) samp_d[0] = s_sync;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Edge, not level: a line stuck low must
                // return high before another frame starts.
                if (!s_sync && s_prev_q) begin
                    state_d = START;
                    // Detection cycle is tick 0 of the start bit.
                    cnt_d   = CW'(1);
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == T_HI) begin
                    if (maj) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        // Counter keeps running so every data
                        // decision lands on MID+1 of its own bit.
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
            end
            DATA: begin
                cnt_d = (cnt_q == T_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == T_HI) begin
                    shift_d = DATA_BITS'({maj, shift_q} >> 1);
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_d = (cnt_q == T_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == T_HI) begin
                    if (even_parity(32'(shift_q)) != maj) perr_d = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                cnt_d = (cnt_q == T_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == T_HI) begin
                    if (maj) load = 1'b1;
                    else ferr_d = 1'b1;
                    // Leave mid-stop so a back-to-back start is seen.
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A load beats a same-cycle ack.
        if (load) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_ack) ovr_d = 1'b1;
        end else if (rx_ack) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge baud_clk) begin
        if (nrst) begin
            state_q  <= IDLE;
            s_prev_q <= 1'b1;
            cnt_q    <= '0;
            samp_q   <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            s_prev_q <= s_prev_d;
            cnt_q    <= cnt_d;
            samp_q   <= samp_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign rx_valid  = valid_q;
    assign busy_rx   = busy_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (vector table, corner sequences,
// random frames against a frame-level model). Honours UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LAT = 2 + NBITS * OS - 7;

    logic       baud_clk;
    logic       nrst;
    logic       sin;
    logic       rx_ack;
    logic [7:0] dout;
    logic       rx_valid;
    logic       busy_rx;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip;
`endif

    int n_cmp;
    int n_bad;

    uart_rx dut (
        .baud_clk  (baud_clk),
        .nrst      (nrst),
        .sin       (sin),
        .rx_ack    (rx_ack),
        .dout      (dout),
        .rx_valid  (rx_valid),
        .busy_rx   (busy_rx),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    typedef struct packed {
        logic       rst;
        logic [7:0] d;
        logic       stop;
        logic       ack;
        logic [7:0] e_dout;
        logic       e_valid;
        logic       e_ferr;
        logic       e_ovr;
    } vec_t;

    vec_t tbl [7];

    task automatic tick(input int n);
        repeat (n) @(posedge baud_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic do_reset();
        nrst = 1'b1;
        tick(3);
        nrst = 1'b0;
        tick(3);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        sin = 1'b0;
        tick(OS);
        for (int i = 0; i < 8; i++) begin
            sin = d[i];
            tick(OS);
        end
`ifdef UART_RX_PARITY_EN
        sin = (^d) ^ par_flip;
        tick(OS);
`endif
        sin = stop;
        tick(OS);
        sin = 1'b1;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    // Cycle-accurate good frame; rx_ack is high only in cycle ack_at.
    task automatic frame_timed(input logic [7:0] d, input int ack_at,
                               output int lat);
        logic [10:0] fa;
`ifdef UART_RX_PARITY_EN
        fa = {1'b1, ^d, d, 1'b0};
`else
        fa = {2'b11, d, 1'b0};
`endif
        lat = -1;
        for (int c = 0; c < NBITS * OS; c++) begin
            sin    = fa[c / OS];
            rx_ack = (c == ack_at);
            tick(1);
            if (rx_valid && lat < 0) lat = c + 1;
            if (c == 2 * OS) check("busy_mid_frame", 32'(busy_rx), 32'd1);
        end
        rx_ack = 1'b0;
        sin    = 1'b1;
    endtask

    logic [7:0] m_dout;
    logic       m_valid;
    logic       m_ferr;
    logic       m_ovr;

    initial begin
        int lat0;
        int lat;
        n_cmp  = 0;
        n_bad  = 0;
        nrst   = 1'b1;
        sin    = 1'b1;
        rx_ack = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
`endif

        tbl[0] = '{1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0};

        tick(4);
        nrst = 1'b0;
        tick(1);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy_rx), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        tick(4);

        // 0xA5 with latency measured from the start edge.
        frame_timed(8'hA5, -1, lat0);
        n_cmp++;
        if (lat0 < LAT - 1 || lat0 > LAT + 1) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles, expected %0d +/-1",
                     lat0, LAT);
        end
        check("a5_dout", 32'(dout), 32'hA5);
        check("a5_ferr", 32'(frame_err), 32'd0);
        check("a5_busy_end", 32'(busy_rx), 32'd0);
        pulse_ack();
        check("a5_ack_clears", 32'(rx_valid), 32'd0);
        pulse_ack();
        check("ack_idle_ignored", 32'(rx_valid), 32'd0);

        // Short low glitch.
        sin = 1'b0;
        tick(4);
        sin = 1'b1;
        tick(30);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        check("glitch_ferr", 32'(frame_err), 32'd0);
        check("glitch_busy", 32'(busy_rx), 32'd0);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].rst) do_reset();
            send_frame(tbl[i].d, tbl[i].stop);
            check($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
            check($sformatf("vec%0d_valid", i), 32'(rx_valid),
                  32'(tbl[i].e_valid));
            check($sformatf("vec%0d_ferr", i), 32'(frame_err),
                  32'(tbl[i].e_ferr));
            check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(tbl[i].e_ovr));
            if (tbl[i].ack) begin
                pulse_ack();
                check($sformatf("vec%0d_ack", i), 32'(rx_valid), 32'd0);
            end
        end

        // Ack in the very cycle of the load, with a byte still pending.
        tick(4);
        frame_timed(8'h96, lat0 - 1, lat);
        check("ldack_dout", 32'(dout), 32'h96);
        check("ldack_valid", 32'(rx_valid), 32'd1);
        check("ldack_ovr", 32'(overrun), 32'd0);

        // Reset during bit 4 of 0xFF.
        sin = 1'b0;
        tick(OS);
        sin = 1'b1;
        tick(4 * OS + OS / 2);
        nrst = 1'b1;
        tick(2);
        nrst = 1'b0;
        tick(1);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_busy", 32'(busy_rx), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        check("midrst_ovr", 32'(overrun), 32'd0);
        tick(5 * OS);
        check("midrst_no_output", 32'(rx_valid), 32'd0);
        send_frame(8'h5A, 1'b1);
        check("post_rst_dout", 32'(dout), 32'h5A);
        check("post_rst_valid", 32'(rx_valid), 32'd1);
        check("post_rst_ferr", 32'(frame_err), 32'd0);

        // Line held low: one zero frame, then no restart.
        pulse_ack();
        sin = 1'b0;
        tick(3 * NBITS * OS);
        check("stuck_busy", 32'(busy_rx), 32'd0);
        check("stuck_ferr", 32'(frame_err), 32'd1);
        check("stuck_valid", 32'(rx_valid), 32'd0);
        sin = 1'b1;
        tick(2 * OS);

        // Random frames against a frame-level model.
        do_reset();
        m_dout  = 8'h00;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] d;
            logic       stop;
            logic       ack;
            int         gap;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 9) != 0);
            ack  = 1'($urandom_range(0, 1));
            gap  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
            if (!stop && gap < 4) gap = 4;
            send_frame(d, stop);
            if (stop) begin
                if (m_valid) m_ovr = 1'b1;
                m_dout  = d;
                m_valid = 1'b1;
            end else begin
                m_ferr = 1'b1;
            end
            check($sformatf("rnd%0d_dout", k), 32'(dout), 32'(m_dout));
            check($sformatf("rnd%0d_valid", k), 32'(rx_valid), 32'(m_valid));
            check($sformatf("rnd%0d_ferr", k), 32'(frame_err), 32'(m_ferr));
            check($sformatf("rnd%0d_ovr", k), 32'(overrun), 32'(m_ovr));
`ifdef UART_RX_PARITY_EN
            check($sformatf("rnd%0d_perr", k), 32'(parity_err), 32'd0);
`endif
            if (ack) begin
                pulse_ack();
                m_valid = 1'b0;
                check($sformatf("rnd%0d_ack", k), 32'(rx_valid), 32'(m_valid));
            end
            tick(gap);
        end

`ifdef UART_RX_PARITY_EN
        do_reset();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        check("par_bad_perr", 32'(parity_err), 32'd1);
        check("par_bad_dout", 32'(dout), 32'h07);
        check("par_bad_valid", 32'(rx_valid), 32'd1);
        do_reset();
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        check("par_ok_perr", 32'(parity_err), 32'd0);
        check("par_ok_dout", 32'(dout), 32'h07);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
